mac_job_sequencer: RTL and testbench
====================================

// Module: mac_job_sequencer
// PURPOSE
//  Sequences one mac_unit through a dot-product job of K weight/input pairs.
//  - Accepts a job descriptor (base address, length).
//  - Reads the operand pairs from a 1-cycle-latency operand memory.
//  - Drives the MAC's clear_acc, enable and operand ports.
//  - Captures the final accumulator and returns it on a valid/ready result port.
//  Sits between the job-issue logic and the MAC datapath.
// PARAMETERS
//  DATA_W   8   operand width (signed)
//  ACC_W    20  accumulator/result width (signed, matches mac_unit)
//  LEN_W    8   job length field width; K = 0 .. 2^LEN_W-1
//  ADDR_W   8   operand memory address width
// PORTS
//  clock            in   1       system clock; single clock domain
//  reset            in   1       synchronous, active-high reset
//  start_valid      in   1       job descriptor valid
//  start_ready      out  1       sequencer can accept a job (high only in IDLE)
//  job_base         in   ADDR_W  first operand address
//  job_len          in   LEN_W   number of MAC operations K
//  mem_rd_en        out  1       operand read strobe
//  mem_rd_addr      out  ADDR_W  operand read address
//  mem_w_data       in   DATA_W  weight; valid the cycle after mem_rd_en
//  mem_i_data       in   DATA_W  input; valid the cycle after mem_rd_en
//  mac_enable       out  1       to mac_unit.enable
//  mac_clear_acc    out  1       to mac_unit.clear_acc
//  mac_weight       out  DATA_W  to mac_unit.weight_in (wire from mem_w_data)
//  mac_input        out  DATA_W  to mac_unit.input_in (wire from mem_i_data)
//  mac_accumulator  in   ACC_W   from mac_unit.accumulator
//  res_valid        out  1       result available
//  res_ready        in   1       result consumer ready
//  res_data         out  ACC_W   captured accumulator
//  busy             out  1       high in every state except IDLE
// BEHAVIOUR
//  - FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
//  - Reset: state=IDLE.
//    - All outputs 0 except start_ready=1: mem_rd_en, mem_rd_addr, mac_enable,
//      mac_clear_acc, res_valid, res_data, busy.
//    - Reset mid-job aborts the job; no result is produced.
//  - IDLE: on start_valid & start_ready, latch job_base and job_len, then go to CLEAR.
//  - CLEAR: 1 cycle with mac_clear_acc=1.
//    - K>0: go to STREAM.
//    - K=0: go to DRAIN for 1 cycle.
//  - STREAM: K cycles, mem_rd_en=1.
//    - mem_rd_addr = base+n for n = 0..K-1, modulo 2^ADDR_W (wraps).
//    - mac_enable is mem_rd_en registered 1 cycle, aligned with the memory data.
//  - DRAIN: 2 cycles when K>0 (last enable, then accumulator settle); 1 cycle when K=0.
//    - At the end of DRAIN, res_data <= mac_accumulator; go to DONE.
//  - DONE: res_valid=1.
//    - res_data is held stable until the res_valid & res_ready handshake.
//    - After the handshake, next state is IDLE.
//    - start_valid is ignored here.
//  - Latency, counting cycle 1 as the first cycle after the start handshake:
//    - K>=1: res_valid first high in cycle K+4.
//    - K=0: res_valid first high in cycle 3; mem_rd_en and mac_enable are never asserted.
//  - Throughput: one job in flight. start_ready returns high the cycle after the result handshake.
//  - No arithmetic is done here; saturation is owned by mac_unit. res_data is passed through bit-exact.
//  - Simultaneous res_ready and start_valid in DONE: the result is accepted; the start is not (start_ready=0).
// CONFIGURATION
//  MAC_SEQ_SAT_FLAG_EN
//  - Defined: adds output res_saturated (1 bit).
//    - Captured with res_data.
//    - High iff the captured value equals 2^(ACC_W-1)-1 or -2^(ACC_W-1).
//    - Reset value 0.
//  - Undefined: port and logic are absent; all other behaviour is identical.
// TESTING
//  1. base=0x00, K=1, mem[0]=(5,3) -> mem_rd_addr=0x00; res_data=15; res_valid in cycle 5.
//  2. K=2, mem[0..1]=(5,3),(2,4) -> res_data=23; exactly 2 mac_enable cycles; one mac_clear_acc pulse.
//  3. K=0 -> res_data=0; res_valid in cycle 3; mem_rd_en never high.
//  4. Saturation:
//     - K=50, all pairs (127,127) -> res_data=0x7FFFF (res_saturated=1 if enabled).
//     - all pairs (-128,127) -> res_data=0x80000.
//  5. res_ready low for 5 cycles in DONE, start_valid held high ->
//     - res_valid and res_data stable; start_ready=0; no new job accepted.
//     - Raise res_ready -> IDLE next cycle.
//  6. Address wrap and mid-job reset:
//     - base=0xFE, K=3 -> addresses FE, FF, 00.
//     - Assert reset during STREAM -> all outputs at reset values next cycle; res_valid never asserted.

Source files
------------

// File: rtl/mac_job_sequencer.sv
// Sequences a mac_unit through one K-element dot-product job read from a 1-cycle-latency operand memory.
// Optional MAC_SEQ_SAT_FLAG_EN adds res_saturated, flagging a captured result at either accumulator rail.
module mac_job_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] job_base,
  input  logic [LEN_W-1:0]  job_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_i_data,
  output logic              mac_enable,
  output logic              mac_clear_acc,
  output logic [DATA_W-1:0] mac_weight,
  output logic [DATA_W-1:0] mac_input,
  input  logic [ACC_W-1:0]  mac_accumulator,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy
`ifdef MAC_SEQ_SAT_FLAG_EN
  ,
  output logic              res_saturated
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              drain_last_q;

  assign mac_weight = mem_w_data;
  assign mac_input  = mem_i_data;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    start_ready   = 1'b0;
    mem_rd_en     = 1'b0;
    mem_rd_addr   = '0;
    mac_clear_acc = 1'b0;
    res_valid     = 1'b0;
    busy          = 1'b1;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_d = CLEAR;
      end
      CLEAR: begin
        mac_clear_acc = 1'b1;
        state_d       = (len_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = addr_q;
        if (cnt_q == LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_last_q) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // drain_last_q is primed in CLEAR: an empty job needs one DRAIN cycle, otherwise
  // one extra cycle covers the final enable plus accumulator settle.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      drain_last_q <= 1'b0;
      mac_enable   <= 1'b0;
      res_data     <= '0;
    end else begin
      mac_enable <= mem_rd_en;
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            addr_q <= job_base;
            len_q  <= job_len;
            cnt_q  <= job_len;
          end
        end
        CLEAR: drain_last_q <= (len_q == '0);
        STREAM: begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 1'b1;
        end
        DRAIN: begin
          if (drain_last_q) res_data <= mac_accumulator;
          else              drain_last_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MAC_SEQ_SAT_FLAG_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  always_ff @(posedge clock) begin
    if (reset) begin
      res_saturated <= 1'b0;
    end else if (state_q == DRAIN && drain_last_q) begin
      res_saturated <= (mac_accumulator == ACC_MAX) || (mac_accumulator == ACC_MIN);
    end
  end
`endif

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Bench for mac_job_sequencer: operand memory and saturating MAC models, table vectors,
// DONE-stall and mid-job-reset sequences, then random jobs against a dot-product reference.
module tb_mac_job_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  job_base;
  logic [7:0]  job_len;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [7:0]  mem_w_data;
  logic [7:0]  mem_i_data;
  logic        mac_enable;
  logic        mac_clear_acc;
  logic [7:0]  mac_weight;
  logic [7:0]  mac_input;
  logic [19:0] mac_accumulator;
  logic        res_valid;
  logic        res_ready;
  logic [19:0] res_data;
  logic        busy;
`ifdef MAC_SEQ_SAT_FLAG_EN
  logic        res_saturated;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mac_job_sequencer #(.DATA_W(8), .ACC_W(20), .LEN_W(8), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .job_base(job_base), .job_len(job_len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_w_data(mem_w_data), .mem_i_data(mem_i_data),
    .mac_enable(mac_enable), .mac_clear_acc(mac_clear_acc),
    .mac_weight(mac_weight), .mac_input(mac_input),
    .mac_accumulator(mac_accumulator),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
`ifdef MAC_SEQ_SAT_FLAG_EN
    , .res_saturated(res_saturated)
`endif
  );

  // Operand memory (1-cycle read latency) and mac_unit environment model.
  logic signed [7:0] w_mem [256];
  logic signed [7:0] i_mem [256];
  logic signed [19:0] acc_m;

  function automatic logic [19:0] sat20(input longint v);
    longint c;
    c = v;
    if (c > 524287)  c = 524287;
    if (c < -524288) c = -524288;
    return c[19:0];
  endfunction

  always @(posedge clock) begin
    if (mem_rd_en) begin
      mem_w_data <= w_mem[mem_rd_addr];
      mem_i_data <= i_mem[mem_rd_addr];
    end
  end

  always @(posedge clock) begin
    if (reset || mac_clear_acc) acc_m <= '0;
    else if (mac_enable)
      acc_m <= sat20(longint'(acc_m) + longint'($signed(mac_weight)) * longint'($signed(mac_input)));
  end
  assign mac_accumulator = acc_m;

  // Cumulative activity log; tasks snapshot it before each job.
  logic [7:0] addr_log[$];
  int en_cnt  = 0;
  int clr_cnt = 0;
  always @(negedge clock) begin
    if (mem_rd_en)     addr_log.push_back(mem_rd_addr);
    if (mac_enable)    en_cnt++;
    if (mac_clear_acc) clr_cnt++;
  end

  // Expected result: running dot product over wrapped addresses, clamped to the 20-bit rails at each step.
  function automatic logic [19:0] ref_dot(input int base, input int len);
    longint a;
    a = 0;
    for (int n = 0; n < len; n++) begin
      a = a + longint'(w_mem[(base + n) % 256]) * longint'(i_mem[(base + n) % 256]);
      if (a > 524287)  a = 524287;
      if (a < -524288) a = -524288;
    end
    return a[19:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctl"}, 32'({start_ready, mem_rd_en, mac_enable, mac_clear_acc, res_valid, busy}),
          32'b100000);
    check({tag, " rd_addr"}, 32'(mem_rd_addr), 32'h0);
    check({tag, " res_data"}, 32'(res_data), 32'h0);
`ifdef MAC_SEQ_SAT_FLAG_EN
    check({tag, " res_saturated"}, 32'(res_saturated), 32'h0);
`endif
  endtask

  task automatic run_job(input string tag, input int base, input int len, input logic [19:0] exp_data,
                         input int stall, input bit hold_start);
    int a0, e0, c0, c1, lat, bad, exp_lat;
    logic [19:0] d0;
    bit stable_ok;
    exp_lat = (len == 0) ? 3 : len + 4;
    @(negedge clock);
    a0 = addr_log.size(); e0 = en_cnt; c0 = clr_cnt;
    check({tag, " start_ready"}, 32'(start_ready), 32'h1);
    start_valid = 1'b1;
    job_base    = base[7:0];
    job_len     = len[7:0];
    @(posedge clock);
    #1 start_valid = 1'b0;
    lat = 0;
    while (lat < 400) begin
      @(negedge clock);
      lat++;
      if (res_valid) break;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " res_data"}, 32'(res_data), 32'(exp_data));
`ifdef MAC_SEQ_SAT_FLAG_EN
    check({tag, " res_saturated"}, 32'(res_saturated),
          32'((exp_data == 20'h7FFFF) || (exp_data == 20'h80000)));
`endif
    check({tag, " rd_count"}, 32'(addr_log.size() - a0), 32'(len));
    bad = 0;
    for (int n = 0; n < len && (a0 + n) < addr_log.size(); n++)
      if (addr_log[a0 + n] != 8'((base + n) % 256)) bad++;
    check({tag, " rd_addr_seq_errs"}, 32'(bad), 32'h0);
    check({tag, " enable_count"}, 32'(en_cnt - e0), 32'(len));
    check({tag, " clear_pulses"}, 32'(clr_cnt - c0), 32'h1);
    d0 = res_data;
    c1 = clr_cnt;
    stable_ok = 1'b1;
    if (hold_start) start_valid = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      if (!res_valid || res_data !== d0 || start_ready || !busy) stable_ok = 1'b0;
    end
    if (stall > 0) check({tag, " done_hold_stable"}, 32'(stable_ok), 32'h1);
    res_ready = 1'b1;
    @(posedge clock);
    #1;
    res_ready   = 1'b0;
    start_valid = 1'b0;
    check({tag, " idle_after_handshake"}, 32'({start_ready, res_valid, busy}), 32'b100);
    if (hold_start) begin
      @(negedge clock);
      check({tag, " no_job_from_held_start"}, 32'(clr_cnt - c1), 32'h0);
    end
  endtask

  typedef struct {
    string       name;
    int          base;
    int          len;
    int          pat;
    logic [19:0] exp_data;
  } vec_t;

  task automatic fill_pattern(input int pat, input int base, input int len);
    case (pat)
      0: begin
        w_mem[0] = 8'sd5; i_mem[0] = 8'sd3;
        w_mem[1] = 8'sd2; i_mem[1] = 8'sd4;
      end
      1: for (int n = 0; n < len; n++) begin
        w_mem[(base + n) % 256] = 8'sd127; i_mem[(base + n) % 256] = 8'sd127;
      end
      2: for (int n = 0; n < len; n++) begin
        w_mem[(base + n) % 256] = -8'sd128; i_mem[(base + n) % 256] = 8'sd127;
      end
      default: begin
        w_mem[8'hFE] = 8'sd1; i_mem[8'hFE] = 8'sd1;
        w_mem[8'hFF] = 8'sd2; i_mem[8'hFF] = 8'sd2;
        w_mem[8'h00] = 8'sd3; i_mem[8'h00] = 8'sd3;
      end
    endcase
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int base, len;
    bit quiet;
    vecs[0] = '{"k1_basic",    0,     1,  0, 20'd15};
    vecs[1] = '{"k2_basic",    0,     2,  0, 20'd23};
    vecs[2] = '{"k0_empty",    'h10,  0,  0, 20'd0};
    vecs[3] = '{"sat_pos",     'h40,  50, 1, 20'h7FFFF};
    vecs[4] = '{"sat_neg",     'h40,  50, 2, 20'h80000};
    vecs[5] = '{"addr_wrap",   'hFE,  3,  3, 20'd14};

    reset = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    job_base = '0; job_len = '0;
    mem_w_data = '0; mem_i_data = '0;
    for (int i = 0; i < 256; i++) begin w_mem[i] = '0; i_mem[i] = '0; end
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset_state");
    reset = 1'b0;

    foreach (vecs[v]) begin
      fill_pattern(vecs[v].pat, vecs[v].base, vecs[v].len);
      run_job(vecs[v].name, vecs[v].base, vecs[v].len, vecs[v].exp_data, 0, 1'b0);
    end

    // Result held in DONE with start_valid asserted and res_ready low for 5 cycles.
    fill_pattern(0, 0, 2);
    run_job("done_stall", 0, 2, 20'd23, 5, 1'b1);

    // Reset in the middle of STREAM aborts the job.
    for (int i = 0; i < 256; i++) begin w_mem[i] = 8'($urandom); i_mem[i] = 8'($urandom); end
    @(negedge clock);
    start_valid = 1'b1; job_base = 8'h20; job_len = 8'd10;
    @(posedge clock);
    #1 start_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("midreset in_stream", 32'(mem_rd_en), 32'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (res_valid || busy) quiet = 1'b0;
    end
    check("midreset no_result", 32'(quiet), 32'h1);

    // Random jobs over random memory, with random result back-pressure.
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < 256; i++) begin w_mem[i] = 8'($urandom); i_mem[i] = 8'($urandom); end
      base = int'($urandom_range(0, 255));
      len  = (j % 8 == 7) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 40));
      run_job($sformatf("rand%0d", j), base, len, ref_dot(base, len),
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
